// File: rtl/rvfi_ctrl_pkg.sv
// Shared types and helpers for the RVFI check sequencer: FSM state encoding
// and per-channel slicing of the packed rvfi_order bus.
package rvfi_ctrl_pkg;

   localparam int MAX_NRET = 8;

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      WARMUP = 2'd1,
      ARMED  = 2'd2,
      DONE   = 2'd3
   } seq_state_t;

   // Callers zero-pad their NRET-wide bus up to MAX_NRET channels.
   function automatic logic [63:0] chan_order(input logic [64*MAX_NRET-1:0] bus, input int idx);
      return bus[64*idx +: 64];
   endfunction

endpackage

// File: rtl/rvfi_check_sequencer_if.sv
// RVFI retirement bus as seen by the check sequencer, plus the sequencer's
// status outputs toward the rvfi_*_check checkers.
interface rvfi_check_sequencer_if #(
   parameter int NRET = 1,
   parameter int CW   = 16
);
   logic [NRET-1:0]    rvfi_valid;
   logic [NRET-1:0]    rvfi_trap;
   logic [64*NRET-1:0] rvfi_order;

   logic               check;
   logic [63:0]        check_order;
   logic               armed;
   logic               done;
   logic               timeout;
   logic [CW-1:0]      depth;

   modport master (
      output rvfi_valid, rvfi_trap, rvfi_order,
      input  check, check_order, armed, done, timeout, depth
   );

   modport slave (
      input  rvfi_valid, rvfi_trap, rvfi_order,
      output check, check_order, armed, done, timeout, depth
   );
endinterface

// File: rtl/rvfi_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module rvfi_sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         enable,
   input  logic         clear,
   output logic [W-1:0] count,
   output logic         at_max
);

   assign at_max = &count;

   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !at_max) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Single-shot sequencer producing the check strobe for the rvfi_*_check
// checkers: hold after reset, warm up to MIN_DEPTH, fire once or time out.
module rvfi_check_sequencer
   import rvfi_ctrl_pkg::*;
#(
   parameter int NRET       = 1,
   parameter int CHANNEL    = 0,
   parameter int RESET_HOLD = 1,
   parameter int MIN_DEPTH  = 10,
   parameter int MAX_DEPTH  = 20,
   parameter bit SKIP_TRAP  = 1'b1,
   parameter int CW         = 16
) (
   input  logic                   clock,
   input  logic                   resetn,
   rvfi_check_sequencer_if.slave  bus
);

   localparam int HW = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);

   seq_state_t             state;
   seq_state_t             state_nxt;
   logic [HW-1:0]          hold_cnt;
   logic [CW-1:0]          depth;
   logic                   hold_at_max;
   logic                   depth_at_max;
   logic                   qualify;
   logic                   hold_done;
   logic                   warm_done;
   logic                   max_hit;
   logic                   fire;
   logic [63:0]            check_order_q;
   logic                   timeout_q;
   logic [64*MAX_NRET-1:0] order_bus;

   assign qualify   = bus.rvfi_valid[CHANNEL] && !(SKIP_TRAP && bus.rvfi_trap[CHANNEL]);
   assign hold_done = (hold_cnt == HW'(RESET_HOLD));
   assign warm_done = (depth == CW'(MIN_DEPTH - 1));
   assign max_hit   = (depth == CW'(MAX_DEPTH));

   rvfi_sat_counter #(.W(HW)) u_hold_cnt (
      .clock  (clock),
      .resetn (resetn),
      .enable (state == HOLD),
      .clear  (1'b0),
      .count  (hold_cnt),
      .at_max (hold_at_max)
   );

   rvfi_sat_counter #(.W(CW)) u_depth (
      .clock  (clock),
      .resetn (resetn),
      .enable (state != HOLD),
      .clear  (state == HOLD),
      .count  (depth),
      .at_max (depth_at_max)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      case (state)
         HOLD:    if (hold_done) state_nxt = WARMUP;
         WARMUP:  if (warm_done) state_nxt = ARMED;
         ARMED: begin
            // Mealy strobe: checkers see rvfi_valid and check in the same cycle.
            fire = qualify;
            if (qualify || max_hit) state_nxt = DONE;
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = HOLD;
      endcase
   end

   always_comb begin
      order_bus                = '0;
      order_bus[64*NRET-1:0]   = bus.rvfi_order;
   end

   // A qualifying retirement at MAX_DEPTH takes priority over the timeout.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         check_order_q <= '0;
         timeout_q     <= 1'b0;
      end else if (state == ARMED) begin
         if (qualify) begin
            check_order_q <= chan_order(order_bus, CHANNEL);
         end else if (max_hit) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.check       = fire;
   assign bus.check_order = check_order_q;
   assign bus.armed       = (state == ARMED);
   assign bus.done        = (state == DONE);
   assign bus.timeout     = timeout_q;
   assign bus.depth       = depth;

   logic unused_ok;
   assign unused_ok = &{1'b0, hold_at_max, depth_at_max};

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Directed, table-driven bench for rvfi_check_sequencer on a two-channel bus
// with channel 1 checked and channel 0 carrying contrary noise.
module tb_rvfi_check_sequencer;

   localparam int NRET      = 2;
   localparam int CHANNEL   = 1;
   localparam int MIN_DEPTH = 10;
   localparam int MAX_DEPTH = 20;
   localparam int CW        = 16;
   // Slot s is the cycle after the (s+1)-th rising edge following reset release;
   // slot 0 is HOLD, slot s>=1 has depth s-1.
   localparam int ARM_SLOT  = MIN_DEPTH + 1;
   localparam int LAST_ARM  = MAX_DEPTH + 1;
   localparam int TO_SLOT   = MAX_DEPTH + 2;

   logic clock  = 1'b0;
   logic resetn = 1'b1;

   always #5 clock = ~clock;

   rvfi_check_sequencer_if #(.NRET(NRET), .CW(CW)) bus ();

   rvfi_check_sequencer #(
      .NRET       (NRET),
      .CHANNEL    (CHANNEL),
      .RESET_HOLD (1),
      .MIN_DEPTH  (MIN_DEPTH),
      .MAX_DEPTH  (MAX_DEPTH),
      .SKIP_TRAP  (1'b1),
      .CW         (CW)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      string       name;
      int          slot;
      bit          first;
      logic        valid;
      logic        trap;
      logic [63:0] order;
      logic        e_check;
      logic        e_armed;
      logic        e_done;
      logic        e_timeout;
      logic [CW-1:0] e_depth;
      logic [63:0] e_order;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Channel 0 gets the opposite valid and a distinctive order so any
   // cross-channel leak shows up as a wrong check or check_order.
   task automatic drive(input logic valid, input logic trap, input logic [63:0] order);
      bus.rvfi_valid = {valid, ~valid};
      bus.rvfi_trap  = {trap, 1'b0};
      bus.rvfi_order = {order, 64'hDEAD_BEEF_0000_0000};
   endtask

   task automatic check_idle(input string name);
      check({name, ".check"},       64'(bus.check),   64'd0);
      check({name, ".armed"},       64'(bus.armed),   64'd0);
      check({name, ".done"},        64'(bus.done),    64'd0);
      check({name, ".timeout"},     64'(bus.timeout), 64'd0);
      check({name, ".depth"},       64'(bus.depth),   64'd0);
      check({name, ".check_order"}, bus.check_order,  64'd0);
   endtask

   // Asserts reset wherever the run currently is, holds it three edges with
   // the bus busy, then releases on a falling edge.
   task automatic start_run(input string name);
      resetn         = 1'b0;
      bus.rvfi_valid = '1;
      bus.rvfi_trap  = '0;
      bus.rvfi_order = '1;
      #1;
      check_idle({name, ".rst_async"});
      repeat (3) @(posedge clock);
      #1;
      check_idle({name, ".rst_held"});
      @(negedge clock);
      drive(1'b0, 1'b0, 64'd0);
      resetn = 1'b1;
   endtask

   // fire_slot < 0 means the run is expected to time out.
   task automatic add_run(input string name, input int nslots, input int fire_slot,
                          input logic [63:0] fire_order, input int valid_from, input int valid_to,
                          input int trap_from, input int trap_to);
      for (int s = 0; s < nslots; s++) begin
         vec_t v;
         int   done_from;
         done_from   = (fire_slot < 0) ? TO_SLOT : fire_slot + 1;
         v.name      = name;
         v.slot      = s;
         v.first     = (s == 0);
         v.valid     = (s >= valid_from) && (s <= valid_to);
         v.trap      = (s >= trap_from) && (s <= trap_to);
         v.order     = (s == fire_slot) ? fire_order : 64'h100 + 64'(s);
         v.e_check   = (s == fire_slot);
         v.e_armed   = (s >= ARM_SLOT) && (s <= ((fire_slot < 0) ? LAST_ARM : fire_slot));
         v.e_done    = (s >= done_from);
         v.e_timeout = (fire_slot < 0) && (s >= TO_SLOT);
         v.e_depth   = (s == 0) ? '0 : CW'(s - 1);
         v.e_order   = (fire_slot >= 0 && s > fire_slot) ? fire_order : 64'd0;
         vecs.push_back(v);
      end
   endtask

   initial begin
      string tag;

      add_run("every",  25, 11, 64'h10B, 0, 24, -1, -2);
      add_run("d12",    17, 13, 64'h2A, 13, 13, -1, -2);
      add_run("none",   25, -1, 64'd0, -1, -2, -1, -2);
      add_run("trap",   20, 16, 64'h55, 11, 16, 11, 15);
      add_run("d20",    25, 21, 64'h77, 21, 21, -1, -2);
      add_run("midrst", 17, -1, 64'd0, -1, -2, -1, -2);
      add_run("replay", 14, -1, 64'd0, -1, -2, -1, -2);

      drive(1'b0, 1'b0, 64'd0);
      #2;

      foreach (vecs[i]) begin
         if (vecs[i].first) start_run(vecs[i].name);
         @(posedge clock);
         #1;
         drive(vecs[i].valid, vecs[i].trap, vecs[i].order);
         @(negedge clock);
         tag = $sformatf("%s[%0d]", vecs[i].name, vecs[i].slot);
         check({tag, ".check"},       64'(bus.check),   64'(vecs[i].e_check));
         check({tag, ".armed"},       64'(bus.armed),   64'(vecs[i].e_armed));
         check({tag, ".done"},        64'(bus.done),    64'(vecs[i].e_done));
         check({tag, ".timeout"},     64'(bus.timeout), 64'(vecs[i].e_timeout));
         check({tag, ".depth"},       64'(bus.depth),   64'(vecs[i].e_depth));
         check({tag, ".check_order"}, bus.check_order,  vecs[i].e_order);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
